// File: rtl/zeroheti_pkg.sv
// rtl/zeroheti_pkg.sv - shared register offsets, APB states and constants for the mtimer
package zeroheti_pkg;

    typedef enum logic [2:0] {
        MTIME_LO = 3'd0,
        MTIME_HI = 3'd1,
        CMP_LO   = 3'd2,
        CMP_HI   = 3'd3,
        CTRL     = 3'd4
    } mtimer_reg_e;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    localparam int          MtimerCtrlEnBit = 0;
    localparam logic [63:0] MtimerCmpRst    = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/zeroheti_apb_sbr_fsm.sv
// rtl/zeroheti_apb_sbr_fsm.sv - APB completer handshake FSM with one wait state per transfer
module zeroheti_apb_sbr_fsm
    import zeroheti_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psel_i,
    input  logic       penable_i,
    input  logic       pwrite_i,
    input  logic [2:0] addr_i,
    output logic       wr_en,
    output logic       rd_en,
    output logic [2:0] addr_q,
    output logic       pready_o
);

    apb_state_e state_q, state_d;
    logic       write_q;
    logic       start;

    always_comb begin
        start   = psel_i & ~penable_i;
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            APB_IDLE:   if (start) state_d = APB_SETUP;
            APB_SETUP: begin
                // register file acts on this edge so its response is registered into ACCESS
                state_d = APB_ACCESS;
                wr_en   = write_q;
                rd_en   = ~write_q;
            end
            APB_ACCESS: state_d = start ? APB_SETUP : APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= APB_IDLE;
            pready_o <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pready_o <= (state_q == APB_SETUP);
            if (state_d == APB_SETUP) begin
                addr_q  <= addr_i;
                write_q <= pwrite_i;
            end
        end
    end

endmodule

// File: rtl/zeroheti_apb_mtimer.sv
// rtl/zeroheti_apb_mtimer.sv - APB mtime/mtimecmp timer with level irq; ZEROHETI_MTIMER_PSC_EN adds a prescaler
module zeroheti_apb_mtimer
    import zeroheti_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int PscWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [31:0]          pwdata_i,
    input  logic [3:0]           pstrb_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 irq_o
);

    logic        wr_en, rd_en;
    logic [2:0]  addr_q;
    logic [63:0] mtime_q, mtime_d, cmp_q;
    logic [31:0] snap_q, lo_inc, rd_val, ctrl_rd;
    logic        en_q, tick, inc, addr_bad;
    logic [PscWidth-1:0] psc_q;
    logic        unused_paddr;

    assign unused_paddr = ^{paddr_i[AddrWidth-1:5], paddr_i[1:0]};

    zeroheti_apb_sbr_fsm u_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwrite_i  (pwrite_i),
        .addr_i    (paddr_i[4:2]),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr_q    (addr_q),
        .pready_o  (pready_o)
    );

`ifdef ZEROHETI_MTIMER_PSC_EN
    logic [PscWidth-1:0] psc_cnt_q;

    assign tick = (psc_cnt_q == psc_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psc_q     <= '0;
            psc_cnt_q <= '0;
        end else if (wr_en && addr_q == CTRL) begin
            if (pstrb_i[1]) psc_q <= pwdata_i[8 +: PscWidth];
            psc_cnt_q <= '0;
        end else if (en_q) begin
            psc_cnt_q <= tick ? '0 : psc_cnt_q + PscWidth'(1);
        end
    end
`else
    assign psc_q = '0;
    assign tick  = 1'b1;
`endif

    assign ctrl_rd  = (32'(psc_q) << 8) | 32'(en_q);
    assign addr_bad = (addr_q > 3'd4);

    always_comb begin
        inc     = en_q & tick;
        lo_inc  = mtime_q[31:0] + 32'(inc);
        mtime_d = mtime_q + 64'(inc);
        // a write to one half overrides the increment there; the other half never sees a carry
        if (wr_en && addr_q == MTIME_LO) begin
            mtime_d = {mtime_q[63:32], apply_strb(mtime_q[31:0], pwdata_i, pstrb_i)};
        end else if (wr_en && addr_q == MTIME_HI) begin
            mtime_d = {apply_strb(mtime_q[63:32], pwdata_i, pstrb_i), lo_inc};
        end
        rd_val = '0;
        case (addr_q)
            MTIME_LO: rd_val = mtime_q[31:0];
            MTIME_HI: rd_val = snap_q;
            CMP_LO:   rd_val = cmp_q[31:0];
            CMP_HI:   rd_val = cmp_q[63:32];
            CTRL:     rd_val = ctrl_rd;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q   <= '0;
            cmp_q     <= MtimerCmpRst;
            en_q      <= 1'b0;
            snap_q    <= '0;
            prdata_o  <= '0;
            pslverr_o <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            irq_o     <= (mtime_q >= cmp_q);
            mtime_q   <= mtime_d;
            prdata_o  <= rd_en ? rd_val : '0;
            pslverr_o <= (rd_en | wr_en) & addr_bad;
            if (rd_en && addr_q == MTIME_LO) snap_q <= mtime_q[63:32];
            if (wr_en && addr_q == CMP_LO) cmp_q[31:0] <= apply_strb(cmp_q[31:0], pwdata_i, pstrb_i);
            if (wr_en && addr_q == CMP_HI) cmp_q[63:32] <= apply_strb(cmp_q[63:32], pwdata_i, pstrb_i);
            if (wr_en && addr_q == CTRL && pstrb_i[0]) en_q <= pwdata_i[MtimerCtrlEnBit];
        end
    end

endmodule
